// File: rtl/iob_axil_periph_bridge.sv
// ---------------------------------------------------------------------------
// iob_axil_periph_bridge
//
// Bridges one IOb-native slave port onto N_SLAVES AXI-Lite master ports.
// The target is chosen by a select field in the IOb address. Only one
// transaction is in flight at a time. AXI error responses, decode misses and
// response timeouts are recorded in a sticky status register.
//
// Ports:
//   clk_i, arst_i, cke_i       clock, async active-high reset, clock enable
//   iob_avalid_i/ready_o       IOb request handshake (addr, wdata, wstrb)
//   iob_rvalid_o/rdata_o       IOb read response (one-cycle pulse)
//   err_o / err_clr_i          sticky status {timeout, miss, axi error}, clear
//   axil_aw*/w*/b*             per-slave AXI-Lite write channels
//   axil_ar*/r*                per-slave AXI-Lite read channels
// ---------------------------------------------------------------------------
module iob_axil_periph_bridge #(
   parameter int                ADDR_W      = 32,
   parameter int                DATA_W      = 32,
   parameter int                AXIL_ADDR_W = 22,
   parameter int                N_SLAVES    = 2,
   parameter int                SEL_W       = 3,
   parameter int                SEL_LSB     = 22,
   parameter int                TIMEOUT_W   = 10,
   parameter logic [DATA_W-1:0] ERR_RDATA   = 32'hDEADBEEF
) (
   input  logic                            clk_i,
   input  logic                            arst_i,
   input  logic                            cke_i,
   input  logic                            iob_avalid_i,
   input  logic [ADDR_W-1:0]               iob_addr_i,
   input  logic [DATA_W-1:0]               iob_wdata_i,
   input  logic [DATA_W/8-1:0]             iob_wstrb_i,
   output logic                            iob_ready_o,
   output logic                            iob_rvalid_o,
   output logic [DATA_W-1:0]               iob_rdata_o,
   output logic [2:0]                      err_o,
   input  logic                            err_clr_i,
   output logic [N_SLAVES-1:0]             axil_awvalid_o,
   input  logic [N_SLAVES-1:0]             axil_awready_i,
   output logic [N_SLAVES*AXIL_ADDR_W-1:0] axil_awaddr_o,
   output logic [N_SLAVES*3-1:0]           axil_awprot_o,
   output logic [N_SLAVES-1:0]             axil_wvalid_o,
   input  logic [N_SLAVES-1:0]             axil_wready_i,
   output logic [N_SLAVES*DATA_W-1:0]      axil_wdata_o,
   output logic [N_SLAVES*DATA_W/8-1:0]    axil_wstrb_o,
   input  logic [N_SLAVES-1:0]             axil_bvalid_i,
   output logic [N_SLAVES-1:0]             axil_bready_o,
   input  logic [N_SLAVES*2-1:0]           axil_bresp_i,
   output logic [N_SLAVES-1:0]             axil_arvalid_o,
   input  logic [N_SLAVES-1:0]             axil_arready_i,
   output logic [N_SLAVES*AXIL_ADDR_W-1:0] axil_araddr_o,
   output logic [N_SLAVES*3-1:0]           axil_arprot_o,
   input  logic [N_SLAVES-1:0]             axil_rvalid_i,
   output logic [N_SLAVES-1:0]             axil_rready_o,
   input  logic [N_SLAVES*DATA_W-1:0]      axil_rdata_i,
   input  logic [N_SLAVES*2-1:0]           axil_rresp_i
);

   localparam int STRB_W = DATA_W / 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WADDR,
      ST_WRESP,
      ST_RADDR,
      ST_RDATA
   } stateT;

   stateT                  r_state;
   logic [N_SLAVES-1:0]    r_selOh;
   logic [AXIL_ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0]      r_wdata;
   logic [STRB_W-1:0]      r_wstrb;
   logic [TIMEOUT_W-1:0]   r_timeoutCnt;
   logic                   r_ready;
   logic                   r_rvalid;
   logic [DATA_W-1:0]      r_rdata;
   logic [2:0]             r_err;
   logic                   r_awvalid;
   logic                   r_wvalid;
   logic                   r_bready;
   logic                   r_arvalid;
   logic                   r_rready;

   logic [SEL_W-1:0]       w_sel;
   logic [N_SLAVES-1:0]    w_selOh;
   logic                   w_miss;
   logic                   w_isWrite;
   logic                   w_accept;
   logic [1:0]             w_bresp;
   logic [1:0]             w_rresp;
   logic [DATA_W-1:0]      w_rdata;
   logic                   w_awHs;
   logic                   w_wHs;
   logic                   w_bHs;
   logic                   w_arHs;
   logic                   w_rHs;
   logic [TIMEOUT_W-1:0]   w_cntNext;
   logic                   w_timeout;
   logic [2:0]             w_errSet;
   logic                   w_unusedAddr;

   // Only the low address bits and the select field matter; the rest of the
   // IOb address is folded here so it is visibly consumed.
   assign w_unusedAddr = ^iob_addr_i;

   assign w_sel     = iob_addr_i[SEL_LSB +: SEL_W];
   assign w_miss    = ~|w_selOh;
   assign w_isWrite = |iob_wstrb_i;
   assign w_accept  = (r_state == ST_IDLE) && iob_avalid_i && r_ready;

   // One-hot slave decode of the incoming request; an all-zero result means
   // the select field points past the last populated slave.
   always_comb begin
      w_selOh = '0;
      for (int k = 0; k < N_SLAVES; k++)
         w_selOh[k] = (w_sel == SEL_W'(k));
   end

   // Response fields of the slave latched at acceptance.
   always_comb begin
      w_bresp = '0;
      w_rresp = '0;
      w_rdata = '0;
      for (int k = 0; k < N_SLAVES; k++) begin
         if (r_selOh[k]) begin
            w_bresp = axil_bresp_i[2*k +: 2];
            w_rresp = axil_rresp_i[2*k +: 2];
            w_rdata = axil_rdata_i[DATA_W*k +: DATA_W];
         end
      end
   end

   assign w_awHs = r_awvalid && |(axil_awready_i & r_selOh);
   assign w_wHs  = r_wvalid  && |(axil_wready_i  & r_selOh);
   assign w_bHs  = r_bready  && |(axil_bvalid_i  & r_selOh);
   assign w_arHs = r_arvalid && |(axil_arready_i & r_selOh);
   assign w_rHs  = r_rready  && |(axil_rvalid_i  & r_selOh);

   // The timeout fires on the waiting cycle that would bring the counter to
   // all-ones. A B or R handshake landing in that same cycle has already been
   // seen by the slave, so completion takes priority over abandoning.
   assign w_cntNext = r_timeoutCnt + TIMEOUT_W'(1);
   assign w_timeout = (r_state != ST_IDLE) && (&w_cntNext) && !(w_bHs || w_rHs);

   assign w_errSet[0] = (w_bHs && (w_bresp != 2'b00)) || (w_rHs && (w_rresp != 2'b00));
   assign w_errSet[1] = w_accept && w_miss;
   assign w_errSet[2] = w_timeout;

   // Main controller: every output is a register, decoded per slave below.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         r_state      <= ST_IDLE;
         r_selOh      <= '0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_wstrb      <= '0;
         r_timeoutCnt <= '0;
         r_ready      <= 1'b1;
         r_rvalid     <= 1'b0;
         r_rdata      <= '0;
         r_err        <= 3'b000;
         r_awvalid    <= 1'b0;
         r_wvalid     <= 1'b0;
         r_bready     <= 1'b0;
         r_arvalid    <= 1'b0;
         r_rready     <= 1'b0;
      end else if (cke_i) begin
         r_rvalid <= 1'b0;
         r_err    <= (err_clr_i ? 3'b000 : r_err) | w_errSet;
         if (r_state != ST_IDLE)
            r_timeoutCnt <= w_cntNext;
         if (w_timeout) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_ready   <= 1'b1;
            r_state   <= ST_IDLE;
            if (r_state == ST_RADDR || r_state == ST_RDATA) begin
               r_rvalid <= 1'b1;
               r_rdata  <= ERR_RDATA;
            end
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_accept) begin
                     r_timeoutCnt <= '0;
                     r_selOh      <= w_selOh;
                     r_addr       <= iob_addr_i[AXIL_ADDR_W-1:0];
                     r_wdata      <= iob_wdata_i;
                     r_wstrb      <= iob_wstrb_i;
                     if (w_miss) begin
                        if (!w_isWrite) begin
                           r_rvalid <= 1'b1;
                           r_rdata  <= ERR_RDATA;
                        end
                     end else if (w_isWrite) begin
                        r_ready   <= 1'b0;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_state   <= ST_WADDR;
                     end else begin
                        r_ready   <= 1'b0;
                        r_arvalid <= 1'b1;
                        r_state   <= ST_RADDR;
                     end
                  end
               end
               ST_WADDR: begin
                  if (w_awHs) r_awvalid <= 1'b0;
                  if (w_wHs)  r_wvalid  <= 1'b0;
                  if ((!r_awvalid || w_awHs) && (!r_wvalid || w_wHs)) begin
                     r_bready <= 1'b1;
                     r_state  <= ST_WRESP;
                  end
               end
               ST_WRESP: begin
                  if (w_bHs) begin
                     r_bready <= 1'b0;
                     r_ready  <= 1'b1;
                     r_state  <= ST_IDLE;
                  end
               end
               ST_RADDR: begin
                  if (w_arHs) begin
                     r_arvalid <= 1'b0;
                     r_rready  <= 1'b1;
                     r_state   <= ST_RDATA;
                  end
               end
               ST_RDATA: begin
                  if (w_rHs) begin
                     r_rready <= 1'b0;
                     r_rdata  <= w_rdata;
                     r_rvalid <= 1'b1;
                     r_ready  <= 1'b1;
                     r_state  <= ST_IDLE;
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign iob_ready_o  = r_ready;
   assign iob_rvalid_o = r_rvalid;
   assign iob_rdata_o  = r_rdata;
   assign err_o        = r_err;

   assign axil_awvalid_o = {N_SLAVES{r_awvalid}} & r_selOh;
   assign axil_wvalid_o  = {N_SLAVES{r_wvalid}}  & r_selOh;
   assign axil_bready_o  = {N_SLAVES{r_bready}}  & r_selOh;
   assign axil_arvalid_o = {N_SLAVES{r_arvalid}} & r_selOh;
   assign axil_rready_o  = {N_SLAVES{r_rready}}  & r_selOh;
   assign axil_awaddr_o  = {N_SLAVES{r_addr}};
   assign axil_araddr_o  = {N_SLAVES{r_addr}};
   assign axil_wdata_o   = {N_SLAVES{r_wdata}};
   assign axil_wstrb_o   = {N_SLAVES{r_wstrb}};
   assign axil_awprot_o  = '0;
   assign axil_arprot_o  = '0;

endmodule

// File: tb/tb_iob_axil_periph_bridge.sv
`timescale 1ns/1ps
module tb_iob_axil_periph_bridge;

   localparam int NS = 2;
   localparam int DW = 32;
   localparam int AW = 22;
   localparam int SW = 4;

   logic              clk_i;
   logic              arst_i;
   logic              cke_i;
   logic              iob_avalid_i;
   logic [31:0]       iob_addr_i;
   logic [DW-1:0]     iob_wdata_i;
   logic [SW-1:0]     iob_wstrb_i;
   logic              iob_ready_o;
   logic              iob_rvalid_o;
   logic [DW-1:0]     iob_rdata_o;
   logic [2:0]        err_o;
   logic              err_clr_i;
   logic [NS-1:0]     axil_awvalid_o, axil_awready_i;
   logic [NS*AW-1:0]  axil_awaddr_o, axil_araddr_o;
   logic [NS*3-1:0]   axil_awprot_o, axil_arprot_o;
   logic [NS-1:0]     axil_wvalid_o, axil_wready_i;
   logic [NS*DW-1:0]  axil_wdata_o, axil_rdata_i;
   logic [NS*SW-1:0]  axil_wstrb_o;
   logic [NS-1:0]     axil_bvalid_i, axil_bready_o;
   logic [NS*2-1:0]   axil_bresp_i, axil_rresp_i;
   logic [NS-1:0]     axil_arvalid_o, axil_arready_i;
   logic [NS-1:0]     axil_rvalid_i, axil_rready_o;

   iob_axil_periph_bridge #(
      .ADDR_W(32), .DATA_W(DW), .AXIL_ADDR_W(AW), .N_SLAVES(NS),
      .SEL_W(3), .SEL_LSB(22), .TIMEOUT_W(4), .ERR_RDATA(32'hDEADBEEF)
   ) dut (
      .clk_i(clk_i), .arst_i(arst_i), .cke_i(cke_i),
      .iob_avalid_i(iob_avalid_i), .iob_addr_i(iob_addr_i),
      .iob_wdata_i(iob_wdata_i), .iob_wstrb_i(iob_wstrb_i),
      .iob_ready_o(iob_ready_o), .iob_rvalid_o(iob_rvalid_o),
      .iob_rdata_o(iob_rdata_o), .err_o(err_o), .err_clr_i(err_clr_i),
      .axil_awvalid_o(axil_awvalid_o), .axil_awready_i(axil_awready_i),
      .axil_awaddr_o(axil_awaddr_o), .axil_awprot_o(axil_awprot_o),
      .axil_wvalid_o(axil_wvalid_o), .axil_wready_i(axil_wready_i),
      .axil_wdata_o(axil_wdata_o), .axil_wstrb_o(axil_wstrb_o),
      .axil_bvalid_i(axil_bvalid_i), .axil_bready_o(axil_bready_o),
      .axil_bresp_i(axil_bresp_i),
      .axil_arvalid_o(axil_arvalid_o), .axil_arready_i(axil_arready_i),
      .axil_araddr_o(axil_araddr_o), .axil_arprot_o(axil_arprot_o),
      .axil_rvalid_i(axil_rvalid_i), .axil_rready_o(axil_rready_o),
      .axil_rdata_i(axil_rdata_i), .axil_rresp_i(axil_rresp_i)
   );

   // Scoreboard state: expected responses are queued when stimulus is issued
   // and retired by the monitor when the DUT presents the matching event.
   logic [31:0] expRd[$];
   logic [63:0] expAr[$];
   logic [63:0] expAw[$];
   logic [63:0] expW[$];
   int          checks = 0;
   int          errors = 0;
   int          rvCount = 0;
   int          bCount = 0;
   int          rvBefore = 0;
   time         tAccept = 0;
   time         tRvalid = 0;

   // Slave model knobs shared by every slave port.
   logic        cfgArReady = 1'b1;
   logic        cfgRHold = 1'b0;
   int          cfgWDelay = 0;
   logic [31:0] cfgRdata = '0;
   logic [1:0]  cfgRresp = 2'b00;
   logic [1:0]  cfgBresp = 2'b00;

   // Free-running clock, 10 ns period.
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
      end
   endtask

   task automatic reportUnexpected(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s actual=event expected=none", name);
   endtask

   function automatic logic [63:0] packAddr(input int k, input logic [31:0] a);
      return {32'(k), a};
   endfunction

   // Issue one IOb request starting from just after a rising edge; returns
   // 1 ns after the edge on which the request was accepted.
   task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
      int n = 0;
      rvBefore     = rvCount;
      iob_avalid_i = 1'b1;
      iob_addr_i   = addr;
      iob_wdata_i  = wdata;
      iob_wstrb_i  = wstrb;
      @(negedge clk_i);
      while (!iob_ready_o && n < 50) begin
         @(negedge clk_i);
         n++;
      end
      if (!iob_ready_o) reportUnexpected("accept_timeout");
      @(posedge clk_i);
      tAccept = $time;
      #1;
      iob_avalid_i = 1'b0;
      iob_wstrb_i  = '0;
   endtask

   // Wait (bounded) until the monitor has seen a new read response.
   task automatic waitRvalid(input int budget);
      int n = 0;
      while (rvCount == rvBefore && n < budget) begin
         @(posedge clk_i);
         #1;
         n++;
      end
      if (rvCount == rvBefore) reportUnexpected("rvalid_timeout");
   endtask

   task automatic pulseClear();
      err_clr_i = 1'b1;
      @(posedge clk_i);
      #1;
      err_clr_i = 1'b0;
   endtask

   // AXI-Lite slave model: handshakes are sampled on the falling edge, and
   // the slave's responses are updated just after the following rising edge.
   initial begin
      logic [NS-1:0] sArHs, sRHs, sAwHs, sWHs, sBHs, awDone, wDone;
      int            wCnt [NS];
      axil_awready_i = '0; axil_wready_i = '0; axil_bvalid_i = '0;
      axil_bresp_i   = '0; axil_arready_i = '0; axil_rvalid_i = '0;
      axil_rdata_i   = '0; axil_rresp_i  = '0;
      awDone = '0; wDone = '0;
      for (int k = 0; k < NS; k++) wCnt[k] = 0;
      forever begin
         @(negedge clk_i);
         sArHs = axil_arvalid_o & axil_arready_i;
         sRHs  = axil_rvalid_i  & axil_rready_o;
         sAwHs = axil_awvalid_o & axil_awready_i;
         sWHs  = axil_wvalid_o  & axil_wready_i;
         sBHs  = axil_bvalid_i  & axil_bready_o;
         for (int k = 0; k < NS; k++) begin
            if (sWHs[k]) wCnt[k] = 0;
            else if (axil_wvalid_o[k]) wCnt[k]++;
         end
         @(posedge clk_i);
         #1;
         if (arst_i) begin
            axil_rvalid_i = '0;
            axil_bvalid_i = '0;
            awDone = '0;
            wDone  = '0;
            for (int k = 0; k < NS; k++) wCnt[k] = 0;
         end else begin
            for (int k = 0; k < NS; k++) begin
               if (sRHs[k]) axil_rvalid_i[k] = 1'b0;
               if (sArHs[k] && !cfgRHold) begin
                  axil_rvalid_i[k]          = 1'b1;
                  axil_rdata_i[DW*k +: DW]  = cfgRdata;
                  axil_rresp_i[2*k +: 2]    = cfgRresp;
               end
               if (sBHs[k]) axil_bvalid_i[k] = 1'b0;
               if (sAwHs[k]) awDone[k] = 1'b1;
               if (sWHs[k])  wDone[k]  = 1'b1;
               if (awDone[k] && wDone[k]) begin
                  axil_bvalid_i[k]       = 1'b1;
                  axil_bresp_i[2*k +: 2] = cfgBresp;
                  awDone[k] = 1'b0;
                  wDone[k]  = 1'b0;
               end
            end
         end
         for (int k = 0; k < NS; k++) begin
            axil_awready_i[k] = axil_awvalid_o[k];
            axil_arready_i[k] = axil_arvalid_o[k] && cfgArReady;
            axil_wready_i[k]  = axil_wvalid_o[k] && (wCnt[k] >= cfgWDelay);
         end
      end
   end

   // Monitor: retires scoreboard entries whenever the DUT presents a read
   // response or completes an AXI address/data handshake.
   initial begin
      logic [63:0] e;
      forever begin
         @(negedge clk_i);
         if (!arst_i) begin
            if (iob_rvalid_o) begin
               rvCount++;
               tRvalid = $time;
               if (expRd.size() == 0) reportUnexpected("rvalid_spurious");
               else begin
                  e = {32'h0, expRd.pop_front()};
                  checkOutput("iob_rdata", {32'h0, iob_rdata_o}, e);
               end
            end
            for (int k = 0; k < NS; k++) begin
               if (axil_arvalid_o[k] && axil_arready_i[k]) begin
                  if (expAr.size() == 0) reportUnexpected("ar_spurious");
                  else checkOutput("ar_slave_addr", packAddr(k, 32'(axil_araddr_o[AW*k +: AW])), expAr.pop_front());
               end
               if (axil_awvalid_o[k] && axil_awready_i[k]) begin
                  if (expAw.size() == 0) reportUnexpected("aw_spurious");
                  else checkOutput("aw_slave_addr", packAddr(k, 32'(axil_awaddr_o[AW*k +: AW])), expAw.pop_front());
               end
               if (axil_wvalid_o[k] && axil_wready_i[k]) begin
                  if (expW.size() == 0) reportUnexpected("w_spurious");
                  else checkOutput("w_slave_strb_data", {8'(k), 20'h0, axil_wstrb_o[SW*k +: SW], axil_wdata_o[DW*k +: DW]}, expW.pop_front());
               end
               if (axil_bvalid_i[k] && axil_bready_o[k]) bCount++;
            end
         end
      end
   end

   // Global bound so a stuck handshake can never hang the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=running expected=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed test sequence.
   initial begin
      int  arCycles;
      int  bBefore;
      bit  done;
      time tReady;
      arst_i = 1'b1; cke_i = 1'b1; err_clr_i = 1'b0;
      iob_avalid_i = 1'b0; iob_addr_i = '0; iob_wdata_i = '0; iob_wstrb_i = '0;
      repeat (2) @(negedge clk_i);
      checkOutput("reset_ready", 64'(iob_ready_o), 64'd1);
      checkOutput("reset_rvalid", 64'(iob_rvalid_o), 64'd0);
      checkOutput("reset_rdata", 64'(iob_rdata_o), 64'd0);
      checkOutput("reset_err", 64'(err_o), 64'd0);
      checkOutput("reset_axil_valids", 64'({axil_awvalid_o, axil_wvalid_o, axil_bready_o, axil_arvalid_o, axil_rready_o}), 64'd0);
      arst_i = 1'b0;
      @(posedge clk_i);
      #1;

      // Zero-wait read of slave 1.
      $display("[TB] read slave 1 zero-wait");
      cfgRdata = 32'h1234_5678;
      expAr.push_back(packAddr(1, 32'h10));
      expRd.push_back(32'h1234_5678);
      applyStimulus(32'h0040_0010, 32'h0, 4'h0);
      @(negedge clk_i);
      checkOutput("rd_ready_busy", 64'(iob_ready_o), 64'd0);
      waitRvalid(20);
      checkOutput("rd_latency", 64'(tRvalid - tAccept), 64'd25);
      checkOutput("rd_err", 64'(err_o), 64'd0);

      // Write of slave 0 with W accepted three cycles after AW.
      $display("[TB] write slave 0 delayed wready");
      cfgWDelay = 3;
      bBefore = bCount;
      expAw.push_back(packAddr(0, 32'h8));
      expW.push_back({8'd0, 20'h0, 4'hF, 32'hA5A5_A5A5});
      applyStimulus(32'h0000_0008, 32'hA5A5_A5A5, 4'hF);
      @(negedge clk_i);
      @(negedge clk_i);
      checkOutput("wr_aw_before_w", 64'({axil_awvalid_o, axil_wvalid_o}), 64'h1);
      done = 0;
      for (int n = 0; n < 30 && !done; n++) begin
         @(negedge clk_i);
         if (iob_ready_o) done = 1;
      end
      tReady = $time;
      checkOutput("wr_ready_back", 64'(done), 64'd1);
      checkOutput("wr_ready_latency", 64'(tReady - tAccept), 64'd55);
      @(posedge clk_i);
      #1;
      checkOutput("wr_b_count", 64'(bCount - bBefore), 64'd1);
      checkOutput("wr_err", 64'(err_o), 64'd0);
      cfgWDelay = 0;

      // Read with an unpopulated select value.
      $display("[TB] decode miss read");
      expRd.push_back(32'hDEAD_BEEF);
      applyStimulus(32'h0140_0004, 32'h0, 4'h0);
      @(negedge clk_i);
      checkOutput("miss_ready", 64'(iob_ready_o), 64'd1);
      waitRvalid(10);
      checkOutput("miss_latency", 64'(tRvalid - tAccept), 64'd5);
      checkOutput("miss_err", 64'(err_o), 64'b010);

      // SLVERR on a read, then clear.
      $display("[TB] read slave 0 with slverr");
      pulseClear();
      @(negedge clk_i);
      checkOutput("clr_miss_err", 64'(err_o), 64'd0);
      @(posedge clk_i);
      #1;
      cfgRdata = 32'hCAFE_F00D;
      cfgRresp = 2'b10;
      expAr.push_back(packAddr(0, 32'h24));
      expRd.push_back(32'hCAFE_F00D);
      applyStimulus(32'h0000_0024, 32'h0, 4'h0);
      waitRvalid(20);
      checkOutput("slverr_err", 64'(err_o), 64'b001);
      cfgRresp = 2'b00;
      pulseClear();
      @(negedge clk_i);
      checkOutput("clr_slverr", 64'(err_o), 64'd0);
      @(posedge clk_i);
      #1;

      // Slave that never accepts the read address.
      $display("[TB] read timeout");
      cfgArReady = 1'b0;
      expRd.push_back(32'hDEAD_BEEF);
      applyStimulus(32'h0040_0030, 32'h0, 4'h0);
      arCycles = 0;
      done = 0;
      for (int n = 0; n < 40 && !done; n++) begin
         @(negedge clk_i);
         if (iob_rvalid_o) done = 1;
         else if (axil_arvalid_o[1]) arCycles++;
      end
      checkOutput("tmo_rvalid_seen", 64'(done), 64'd1);
      checkOutput("tmo_arvalid_cycles", 64'(arCycles), 64'd15);
      @(posedge clk_i);
      #1;
      checkOutput("tmo_latency", 64'(tRvalid - tAccept), 64'd155);
      checkOutput("tmo_err", 64'(err_o), 64'b100);
      cfgArReady = 1'b1;
      cfgRdata = 32'h0BAD_F00D;
      expAr.push_back(packAddr(0, 32'h20));
      expRd.push_back(32'h0BAD_F00D);
      applyStimulus(32'h0000_0020, 32'h0, 4'h0);
      waitRvalid(20);
      checkOutput("tmo_err_sticky", 64'(err_o), 64'b100);

      // Reset while waiting for read data.
      $display("[TB] reset during read data phase");
      cfgRHold = 1'b1;
      expAr.push_back(packAddr(1, 32'h3C));
      applyStimulus(32'h0040_003C, 32'h0, 4'h0);
      done = 0;
      for (int n = 0; n < 10 && !done; n++) begin
         @(negedge clk_i);
         if (axil_rready_o[1]) done = 1;
      end
      checkOutput("rst_reached_rdata", 64'(done), 64'd1);
      arst_i = 1'b1;
      #1;
      checkOutput("rst_mid_ready", 64'(iob_ready_o), 64'd1);
      checkOutput("rst_mid_rdata", 64'(iob_rdata_o), 64'd0);
      checkOutput("rst_mid_err", 64'(err_o), 64'd0);
      checkOutput("rst_mid_valids", 64'({axil_arvalid_o, axil_rready_o, iob_rvalid_o}), 64'd0);
      @(negedge clk_i);
      arst_i = 1'b0;
      cfgRHold = 1'b0;
      repeat (4) @(posedge clk_i);
      #1;
      cfgRdata = 32'h600D_CAFE;
      expAr.push_back(packAddr(1, 32'h44));
      expRd.push_back(32'h600D_CAFE);
      applyStimulus(32'h0040_0044, 32'h0, 4'h0);
      waitRvalid(20);
      checkOutput("post_rst_latency", 64'(tRvalid - tAccept), 64'd25);
      checkOutput("post_rst_err", 64'(err_o), 64'd0);

      repeat (3) @(posedge clk_i);
      #1;
      checkOutput("sb_drain_rd", 64'(expRd.size()), 64'd0);
      checkOutput("sb_drain_axi", 64'(expAr.size() + expAw.size() + expW.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
